// File: rtl/piso_pkg.sv
// Shared types for the stream serializer: FSM states, the captured word record
// and the length clamp applied when a word is accepted.
package piso_pkg;

    localparam int unsigned PISO_MAX_W     = 64;
    localparam int unsigned PISO_MAX_LEN_W = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Sized for the widest supported word; unused upper bits fold away.
    typedef struct packed {
        logic [PISO_MAX_W-1:0]     data;
        logic [PISO_MAX_LEN_W-1:0] len;
        logic                      msb_first;
    } piso_word_t;

    function automatic logic [PISO_MAX_LEN_W-1:0] clamp_len(
        input logic [PISO_MAX_LEN_W-1:0] len,
        input int unsigned               data_w
    );
        if (len == '0 || 32'(len) > data_w) begin
            return PISO_MAX_LEN_W'(data_w);
        end
        return len;
    endfunction

endpackage

// File: rtl/piso_stream_serializer_hold_slot.sv
// Single-entry holding register for one accepted word waiting behind the shifter.
// A simultaneous take and load keeps the slot full with the new word.
module piso_hold_slot
    import piso_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic       take_i,
    input  piso_word_t word_i,
    output piso_word_t word_o,
    output logic       full_o
);

    piso_word_t word_q;
    logic       full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            word_q <= word_i;
            full_q <= 1'b1;
        end else if (take_i) begin
            full_q <= 1'b0;
        end
    end

    assign word_o = word_q;
    assign full_o = full_q;

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides, per-word
// length and bit order, and a hold slot so back-to-back words stream gaplessly.
//
// state | meaning
// IDLE  | shifter empty, out_valid low
// SHIFT | shifter presenting bits; rem_q counts bits left including the current one
module piso_stream_serializer
    import piso_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic              busy
);

    piso_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              msb_q, msb_d;

    logic              hold_full, hold_load, hold_take;
    piso_word_t        hold_word, in_word, ld_word;
    logic [DATA_W-1:0] ld_data;
    logic [LEN_W-1:0]  ld_len;
    logic              in_fire, out_fire, last_fire, load_en;
    logic              unused_ld;

    assign in_ready  = !hold_full;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == SHIFT);
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && (rem_q == LEN_W'(1));
    assign out_last  = out_valid && (rem_q == LEN_W'(1));
    assign out_bit   = out_valid && (msb_q ? shift_q[DATA_W-1] : shift_q[0]);
    assign busy      = out_valid || hold_full;

    always_comb begin
        in_word           = '0;
        in_word.data      = PISO_MAX_W'(in_data);
        in_word.len       = clamp_len(PISO_MAX_LEN_W'(in_len), DATA_W);
        in_word.msb_first = in_msb_first;
    end

    // The hold slot is always older than the input port, so it wins the load.
    assign ld_word   = hold_full ? hold_word : in_word;
    assign ld_data   = ld_word.data[DATA_W-1:0];
    assign ld_len    = ld_word.len[LEN_W-1:0];
    assign unused_ld = ^ld_word;

    piso_hold_slot u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (hold_load),
        .take_i  (hold_take),
        .word_i  (in_word),
        .word_o  (hold_word),
        .full_o  (hold_full)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        msb_d     = msb_q;
        load_en   = 1'b0;
        hold_load = 1'b0;
        hold_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    load_en = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hold_load = in_fire && !last_fire;
                if (last_fire) begin
                    if (hold_full) begin
                        load_en   = 1'b1;
                        hold_take = 1'b1;
                    end else if (in_fire) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (out_fire) begin
                    shift_d = msb_q ? (shift_q << 1) : (shift_q >> 1);
                    rem_d   = rem_q - LEN_W'(1);
                end
            end
        endcase
        // MSB-first words are left-aligned so the first bit sits at the top.
        if (load_en) begin
            shift_d = ld_word.msb_first ? (ld_data << (LEN_W'(DATA_W) - ld_len)) : ld_data;
            rem_d   = ld_len;
            msb_d   = ld_word.msb_first;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            msb_q   <= msb_d;
        end
    end

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Self-checking bench: directed words plus randomized traffic against a
// bit-queue reference model built from the word/length/order rules.
module tb_piso_stream_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic       in_msb_first;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
    logic       busy;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] obs_vec  = '0;
    int          obs_cnt  = 0;
    logic        prev_stall = 1'b0;
    logic        prev_bit, prev_last;
    int          bp_mode = 0;
    int          bp_idx  = 0;
    logic [3:0]  bp_pat  = 4'b1001;

    piso_stream_serializer #(.DATA_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_len       (in_len),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit      (out_bit),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_push(input logic [7:0] d, input logic [3:0] l, input logic m);
        int n = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.b    = d[m ? (n - 1 - i) : i];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Handshakes are observed mid-cycle; the transfer itself happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 32'(out_valid), 32'd1);
                check_val("stall_bit", 32'(out_bit), 32'(prev_bit));
                check_val("stall_last", 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_bit   = out_bit;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check_val("out_bit", 32'(out_bit), 32'(cur.b));
                    check_val("out_last", 32'(out_last), 32'(cur.last));
                end
                obs_vec = {obs_vec[30:0], out_bit};
                obs_cnt++;
            end
            if (in_valid && in_ready) model_push(in_data, in_len, in_msb_first);
        end
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1: begin
                out_ready = bp_pat[bp_idx];
                bp_idx    = (bp_idx + 1) % 4;
            end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    task automatic push_word(input logic [7:0] d, input logic [3:0] l, input logic m);
        int guard = 0;
        in_valid     = 1'b1;
        in_data      = d;
        in_len       = l;
        in_msb_first = m;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_val("push_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_val("drain_idle", 32'(busy || exp_q.size() != 0), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_vec = '0;
        obs_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_len       = '0;
        in_msb_first = 1'b0;
        out_ready    = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_bit", 32'(out_bit), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 0xB4, LSB-first: 0,0,1,0,1,1,0,1
        clear_obs();
        check_val("idle_valid", 32'(out_valid), 32'd0);
        push_word(8'hB4, 4'd8, 1'b0);
        check_val("latency_valid", 32'(out_valid), 32'd1);
        wait_idle();
        check_val("lsb_b4_bits", obs_vec, 32'h2D);
        check_val("lsb_b4_cnt", 32'(obs_cnt), 32'd8);
        check_val("lsb_b4_out_valid", 32'(out_valid), 32'd0);

        clear_obs();
        push_word(8'hB4, 4'd8, 1'b1);
        wait_idle();
        check_val("msb_b4_bits", obs_vec, 32'hB4);

        clear_obs();
        push_word(8'h0D, 4'd3, 1'b1);
        wait_idle();
        check_val("len3_bits", obs_vec, 32'h5);
        check_val("len3_cnt", 32'(obs_cnt), 32'd3);

        clear_obs();
        push_word(8'hA5, 4'd0, 1'b1);
        wait_idle();
        check_val("len0_bits", obs_vec, 32'hA5);
        check_val("len0_cnt", 32'(obs_cnt), 32'd8);

        clear_obs();
        push_word(8'h6C, 4'd1, 1'b0);
        wait_idle();
        check_val("len1_cnt", 32'(obs_cnt), 32'd1);
        check_val("len1_bits", obs_vec, 32'h0);

        // Back-to-back words: no bubble, hold slot fills and blocks the input
        clear_obs();
        push_word(8'hFF, 4'd4, 1'b1);
        push_word(8'h00, 4'd4, 1'b0);
        check_val("stream_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_val("stream_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        wait_idle();
        check_val("stream_bits", obs_vec, 32'hF0);
        check_val("stream_cnt", 32'(obs_cnt), 32'd8);

        // out_ready pattern 1,0,0,1
        bp_mode = 1;
        bp_idx  = 0;
        clear_obs();
        push_word(8'hB4, 4'd8, 1'b1);
        wait_idle();
        check_val("bp_bits", obs_vec, 32'hB4);
        check_val("bp_cnt", 32'(obs_cnt), 32'd8);
        bp_mode = 0;
        @(posedge clk);
        #1;

        // Reset mid-word with a word held
        clear_obs();
        push_word(8'hB4, 4'd8, 1'b0);
        push_word(8'h55, 4'd8, 1'b1);
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        check_val("pre_rst_in_ready", 32'(in_ready), 32'd0);
        begin
            int guard = 0;
            while (obs_cnt < 3 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        check_val("pre_rst_bits", 32'(obs_cnt), 32'd3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        push_word(8'h96, 4'd8, 1'b0);
        wait_idle();
        check_val("post_rst_bits", obs_vec, 32'h69);
        check_val("post_rst_cnt", 32'(obs_cnt), 32'd8);

        // Randomized traffic with random back-pressure and input gaps
        bp_mode = 2;
        for (int w = 0; w < 150; w++) begin
            push_word(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        bp_mode = 0;
        wait_idle();
        check_val("final_idle_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. It is the successor to the team's plain PISO shift register. It adds:
- per-word bit length
- per-word MSB-first/LSB-first order
- downstream back-pressure
- a one-word holding slot, so consecutive words stream with no idle cycle between them.

It sits between a parallel word producer and a bit-serial link or encoder.

Parameters:
DATA_W, 8, word width in bits; must be >= 2.
LEN_W, $clog2(DATA_W+1), width of the length field; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer offers a word
in_ready  output  1  block accepts the word this cycle
in_data  input  DATA_W  parallel word; only bits [L-1:0] are sent
in_len  input  LEN_W  bit count L; 0 or >DATA_W means DATA_W
in_msb_first  input  1  1: send bit L-1 first; 0: send bit 0 first
out_valid  output  1  out_bit is valid
out_ready  input  1  consumer takes out_bit this cycle
out_bit  output  1  current serial bit
out_last  output  1  current bit is the final bit of its word
busy  output  1  a word is in the shifter or in the holding slot

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, hold slot empty, shifter=0, remaining count=0.
  - out_valid=0, out_bit=0, out_last=0, busy=0.
  - in_ready=1, but no handshake is honoured while reset_n is low.
  - Asserting reset_n mid-word abandons the word and the held word; no partial completion.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid, out_bit and out_last stay stable until the output transfer completes.
- Capture at acceptance:
  - L = clamp(in_len); a value of 0 or >DATA_W becomes DATA_W.
  - The msb_first flag is captured with the word.
  - MSB-first: the word is left-aligned into the shifter (data << (DATA_W-L)) and shifted left; out_bit = shifter[DATA_W-1].
  - LSB-first: the word is loaded as-is and shifted right; out_bit = shifter[0].
- State machine with two states:
  - IDLE: out_valid=0. An accepted word loads the shifter directly, remaining=L, and the state moves to SHIFT at the next edge. Latency is one cycle from input transfer to first out_valid.
  - SHIFT: out_valid=1 and out_last=(remaining==1). On each output transfer the shifter shifts and remaining decrements.
  - On the output transfer of the last bit:
    - If the hold slot is full, the held word loads the shifter at that edge and the state stays SHIFT (zero-bubble).
    - Else, if an input transfer happens in the same cycle, the new word bypasses into the shifter and the state stays SHIFT.
    - Otherwise the state returns to IDLE.
  - In SHIFT, an input transfer that is not consumed by the bypass fills the hold slot.
- in_ready = !hold_full. It is combinational from registered state only, with no path from in_valid or out_ready.
- busy = (state==SHIFT) || hold_full.
- Back-pressure: while out_ready=0, all state is frozen except for hold-slot filling.
- L=1 produces a single bit with out_last=1.

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_e
  - typedef struct piso_word_t {data, len, msb_first}
  - function clamp_len(), which maps 0 and >DATA_W to DATA_W
- One natural sub-module, piso_hold_slot: a single-entry register of piso_word_t with a full flag and load/take controls.
- The shifter, the counter and the FSM stay in the top module.

Test Plan:
- DATA_W=8. Accept 0xB4, L=8, LSB-first, out_ready=1. Required response:
  - Bits 0,0,1,0,1,1,0,1.
  - First out_valid one cycle after the transfer.
  - out_last only on the 8th bit.
  - Then IDLE with busy=0.
- Same word 0xB4 with MSB-first. Required response: bits 1,0,1,1,0,1,0,0.
- Accept 0x0D, L=3, MSB-first. Required response: bits 1,0,1, out_last on the 3rd bit; in_len=0 sends all 8 bits.
- Stream 0xFF then 0x00, both L=4, with in_valid held high. Required response:
  - Output 1,1,1,1,0,0,0,0 with out_valid never dropping between words.
  - in_ready drops after the second word is held.
- Toggle out_ready 1,0,0,1 repeatedly. Required response:
  - out_bit and out_last hold steady while out_ready=0.
  - The full bit sequence is unchanged.
- Pull reset_n low after 3 of 8 bits, with one word held. Required response:
  - out_valid=0 and busy=0 immediately (asynchronously).
  - After release, a new word streams correctly from its first bit.
